// File: rtl/axi4_lite_pkg.sv
// Shared types and constants for the AXI4-lite initiator.
//   state_e       : transaction FSM states
//   mem_req_t     : native request latched at acceptance
//   PROT_DATA/PROT_INSN : AXI protection encodings for data and fetch accesses
//   TIMEOUT_RDATA : read data returned when the watchdog aborts a transaction
package axi4_lite_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned PROT_W = 3;

    localparam logic [PROT_W-1:0] PROT_DATA     = 3'b000;
    localparam logic [PROT_W-1:0] PROT_INSN     = 3'b100;
    localparam logic [DATA_W-1:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_ADDR_DATA,
        WR_RESP,
        DONE
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
        logic [PROT_W-1:0] prot;
    } mem_req_t;

    // Instruction fetches are flagged through the AXI prot field.
    function automatic logic [PROT_W-1:0] prot_for(input logic instr);
        return instr ? PROT_INSN : PROT_DATA;
    endfunction

endpackage

// File: rtl/axi4_lite_initiator_if.sv
// AXI4-lite channel bundle (AW, W, B, AR, R) without response codes.
//   master modport : initiator side, drives valids/payloads on AW/W/AR and readys on B/R
//   slave modport  : responder side
interface axi4_lite_initiator_if;
    import axi4_lite_pkg::*;

    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [PROT_W-1:0] awprot;

    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;

    logic              bvalid;
    logic              bready;

    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [PROT_W-1:0] arprot;

    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;

    modport master (
        output awvalid, awaddr, awprot,
        input  awready,
        output wvalid, wdata, wstrb,
        input  wready,
        input  bvalid,
        output bready,
        output arvalid, araddr, arprot,
        input  arready,
        input  rvalid, rdata,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awprot,
        output awready,
        input  wvalid, wdata, wstrb,
        output wready,
        output bvalid,
        input  bready,
        input  arvalid, araddr, arprot,
        output arready,
        output rvalid, rdata,
        input  rready
    );

endinterface

// File: rtl/axi4_lite_watchdog.sv
// Wait-cycle watchdog for one AXI4-lite transaction.
//   clk, resetn : clock, synchronous active-low reset
//   clear       : a new transaction is being accepted
//   run         : the transaction is waiting on the responder this cycle
//   expired     : registered; high during the LIMIT-th waiting cycle
module axi4_lite_watchdog #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    // count holds the index of the current waiting cycle, starting at 1.
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count   <= '0;
            expired <= 1'b0;
        end else if (clear) begin
            count   <= CNT_W'(1);
            expired <= 1'b0;
        end else if (run && !expired) begin
            count   <= count + CNT_W'(1);
            expired <= (count == CNT_W'(LIMIT - 1));
        end
    end

endmodule

// File: rtl/axi4_lite_initiator.sv
// Native single-outstanding memory request to AXI4-lite read/write bridge.
//   clk, resetn            : clock, synchronous active-low reset
//   mem_valid/instr/addr/wdata/wstrb : request (wstrb == 0 selects a read)
//   mem_ready              : one-cycle completion pulse
//   mem_rdata              : read data, valid with mem_ready; held across writes
//   mem_err                : sticky watchdog timeout flag
//   mem_axi                : AXI4-lite master port, all outputs registered
// Optional feature macro AXI_INIT_TIMEOUT_EN: aborts a transaction after
// TIMEOUT_CYCLES waiting cycles (debug only, breaks the AXI valid rule).
module axi4_lite_initiator
    import axi4_lite_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 mem_valid,
    input  logic                 mem_instr,
    input  logic [ADDR_W-1:0]    mem_addr,
    input  logic [DATA_W-1:0]    mem_wdata,
    input  logic [STRB_W-1:0]    mem_wstrb,
    output logic                 mem_ready,
    output logic [DATA_W-1:0]    mem_rdata,
    output logic                 mem_err,
    axi4_lite_initiator_if.master mem_axi
);

    // The watchdog count starts at 1 on entry, so a limit below 2 never fires.
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("axi4_lite_initiator: TIMEOUT_CYCLES must be at least 2");
    end

    state_e   state;
    mem_req_t req;
    logic     awvalid_q;
    logic     wvalid_q;
    logic     bready_q;
    logic     arvalid_q;
    logic     rready_q;
    logic     aw_done;
    logic     w_done;
    logic     aw_hs_c;
    logic     w_hs_c;

    assign aw_hs_c = awvalid_q & mem_axi.awready;
    assign w_hs_c  = wvalid_q & mem_axi.wready;

`ifdef AXI_INIT_TIMEOUT_EN
    logic wd_clear_c;
    logic wd_run_c;
    logic wd_expired;
    logic timeout_c;
    logic err_q;

    assign wd_clear_c = (state == IDLE) && mem_valid;
    assign wd_run_c   = (state == RD_ADDR) || (state == RD_DATA) ||
                        (state == WR_ADDR_DATA) || (state == WR_RESP);
    // expired lingers until the next clear; only act on it while waiting.
    assign timeout_c  = wd_expired & wd_run_c;
    assign mem_err    = err_q;

    axi4_lite_watchdog #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (wd_clear_c),
        .run     (wd_run_c),
        .expired (wd_expired)
    );
`else
    assign mem_err = 1'b0;
`endif

    // Transaction FSM; every AXI and native output is a register here.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            req       <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
`ifdef AXI_INIT_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
        end else begin
            mem_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_valid) begin
                        req.addr  <= mem_addr;
                        req.wdata <= mem_wdata;
                        req.wstrb <= mem_wstrb;
                        req.prot  <= prot_for(mem_instr);
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        if (mem_wstrb == '0) begin
                            arvalid_q <= 1'b1;
                            state     <= RD_ADDR;
                        end else begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state     <= WR_ADDR_DATA;
                        end
                    end
                end
                RD_ADDR: begin
                    if (arvalid_q && mem_axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (mem_axi.rvalid) begin
                        rready_q  <= 1'b0;
                        mem_rdata <= mem_axi.rdata;
                        mem_ready <= 1'b1;
                        state     <= DONE;
                    end
                end
                WR_ADDR_DATA: begin
                    // AW and W complete independently; either may finish first.
                    if (aw_hs_c) begin
                        awvalid_q <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_hs_c) begin
                        wvalid_q <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    if ((aw_done || aw_hs_c) && (w_done || w_hs_c)) begin
                        bready_q <= 1'b1;
                        state    <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (mem_axi.bvalid) begin
                        bready_q  <= 1'b0;
                        mem_ready <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
`ifdef AXI_INIT_TIMEOUT_EN
            // Abort overrides whatever the waiting state decided this cycle.
            if (timeout_c) begin
                awvalid_q <= 1'b0;
                wvalid_q  <= 1'b0;
                bready_q  <= 1'b0;
                arvalid_q <= 1'b0;
                rready_q  <= 1'b0;
                err_q     <= 1'b1;
                mem_rdata <= TIMEOUT_RDATA;
                mem_ready <= 1'b1;
                state     <= DONE;
            end
`endif
        end
    end

    assign mem_axi.awvalid = awvalid_q;
    assign mem_axi.awaddr  = req.addr;
    assign mem_axi.awprot  = PROT_DATA;
    assign mem_axi.wvalid  = wvalid_q;
    assign mem_axi.wdata   = req.wdata;
    assign mem_axi.wstrb   = req.wstrb;
    assign mem_axi.bready  = bready_q;
    assign mem_axi.arvalid = arvalid_q;
    assign mem_axi.araddr  = req.addr;
    assign mem_axi.arprot  = req.prot;
    assign mem_axi.rready  = rready_q;

endmodule

// File: tb/tb_axi4_lite_initiator.sv
// Bench for axi4_lite_initiator: directed and randomized transactions against
// a cycle-exact protocol model of the expected AXI and native behaviour.
module tb_axi4_lite_initiator;

    localparam int unsigned TO = 8;

    logic        clk;
    logic        resetn;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_err;

    axi4_lite_initiator_if bus ();

    axi4_lite_initiator #(
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .mem_err   (mem_err),
        .mem_axi   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_rdata = 32'h0;
    logic        exp_err   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic quiet_responder();
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rdata   = 32'h0;
    endtask

    task automatic check_idle(input string tag);
        chk1({tag, "_arvalid"}, bus.arvalid, 1'b0);
        chk1({tag, "_awvalid"}, bus.awvalid, 1'b0);
        chk1({tag, "_wvalid"},  bus.wvalid,  1'b0);
        chk1({tag, "_rready"},  bus.rready,  1'b0);
        chk1({tag, "_bready"},  bus.bready,  1'b0);
        chk1({tag, "_ready"},   mem_ready,   1'b0);
        chk ({tag, "_rdata"},   mem_rdata,   exp_rdata);
        chk1({tag, "_err"},     mem_err,     exp_err);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn    = 1'b0;
        mem_valid = 1'b0;
        quiet_responder();
        repeat (2) @(negedge clk);
        exp_rdata = 32'h0;
        exp_err   = 1'b0;
        check_idle("reset");
        resetn = 1'b1;
    endtask

    // Read: arready after ar_dly waiting cycles, rvalid after r_dly cycles of rready.
    task automatic do_read(input logic [31:0] addr, input logic instr, input logic [31:0] data,
                           input int ar_dly, input int r_dly);
        int ar_hs = 1 + ar_dly;
        int r_beg = ar_hs + 1;
        int lat   = 3 + ar_dly + r_dly;
        @(negedge clk);
        mem_valid = 1'b1;
        mem_instr = instr;
        mem_addr  = addr;
        mem_wdata = $urandom;
        mem_wstrb = 4'h0;
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            chk1("rd_arvalid", bus.arvalid, c <= ar_hs);
            if (bus.arvalid) begin
                chk("rd_araddr", bus.araddr, addr);
                chk("rd_arprot", 32'(bus.arprot), instr ? 32'h4 : 32'h0);
            end
            chk1("rd_rready",  bus.rready,  (c >= r_beg) && (c <= r_beg + r_dly));
            chk1("rd_bready",  bus.bready,  1'b0);
            chk1("rd_awvalid", bus.awvalid, 1'b0);
            chk1("rd_wvalid",  bus.wvalid,  1'b0);
            chk1("rd_ready",   mem_ready,   c == lat);
            if (c == lat) begin
                exp_rdata = data;
                chk("rd_rdata", mem_rdata, exp_rdata);
                mem_valid = 1'b0;
            end
            chk1("rd_err", mem_err, exp_err);
            bus.arready = (c == ar_hs);
            bus.rvalid  = (c == r_beg + r_dly);
            bus.rdata   = bus.rvalid ? data : $urandom;
            bus.bvalid  = 1'($urandom_range(0, 1));
            bus.awready = 1'($urandom_range(0, 1));
            bus.wready  = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        check_idle("rd_after");
        quiet_responder();
    endtask

    // Write: awready/wready after independent delays, bvalid after b_dly cycles of bready.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly);
        int both  = (aw_dly > w_dly) ? aw_dly : w_dly;
        int b_beg = both + 2;
        int lat   = both + 3 + b_dly;
        @(negedge clk);
        mem_valid = 1'b1;
        mem_instr = 1'($urandom_range(0, 1));
        mem_addr  = addr;
        mem_wdata = data;
        mem_wstrb = strb;
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            chk1("wr_awvalid", bus.awvalid, c <= 1 + aw_dly);
            if (bus.awvalid) begin
                chk("wr_awaddr", bus.awaddr, addr);
                chk("wr_awprot", 32'(bus.awprot), 32'h0);
            end
            chk1("wr_wvalid", bus.wvalid, c <= 1 + w_dly);
            if (bus.wvalid) begin
                chk("wr_wdata", bus.wdata, data);
                chk("wr_wstrb", 32'(bus.wstrb), 32'(strb));
            end
            chk1("wr_bready",  bus.bready,  (c >= b_beg) && (c <= b_beg + b_dly));
            chk1("wr_arvalid", bus.arvalid, 1'b0);
            chk1("wr_rready",  bus.rready,  1'b0);
            chk1("wr_ready",   mem_ready,   c == lat);
            if (c == lat) begin
                chk("wr_rdata_held", mem_rdata, exp_rdata);
                mem_valid = 1'b0;
            end
            chk1("wr_err", mem_err, exp_err);
            bus.awready = (c == 1 + aw_dly);
            bus.wready  = (c == 1 + w_dly);
            bus.bvalid  = (c == b_beg + b_dly);
            bus.rvalid  = 1'($urandom_range(0, 1));
            bus.rdata   = $urandom;
            bus.arready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        check_idle("wr_after");
        quiet_responder();
    endtask

    initial begin
        resetn    = 1'b0;
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_wstrb = 4'h0;
        quiet_responder();
        do_reset();

        // Directed cases
        do_read(32'h0000_0100, 1'b0, 32'h1234_5678, 0, 0);
        do_read(32'h2000_0040, 1'b1, 32'h0BAD_F00D, 4, 1);
        do_write(32'h3000_0008, 32'hCAFE_BABE, 4'b0110, 3, 0, 0);
        do_write(32'h3000_000C, 32'h5555_AAAA, 4'b1111, 1, 1, 6);
        do_write(32'h3000_0010, 32'h0102_0304, 4'b0001, 0, 2, 0);

        // Reset during RD_DATA with a pending rvalid beat
        @(negedge clk);
        mem_valid = 1'b1;
        mem_instr = 1'b0;
        mem_addr  = 32'h4000_0000;
        mem_wstrb = 4'h0;
        @(negedge clk);
        chk1("rst_arvalid", bus.arvalid, 1'b1);
        bus.arready = 1'b1;
        @(negedge clk);
        chk1("rst_rready", bus.rready, 1'b1);
        bus.arready = 1'b0;
        bus.rvalid  = 1'b1;
        bus.rdata   = 32'h7777_7777;
        resetn      = 1'b0;
        @(negedge clk);
        exp_rdata = 32'h0;
        exp_err   = 1'b0;
        check_idle("rst_mid");
        resetn    = 1'b1;
        mem_valid = 1'b0;
        @(negedge clk);
        check_idle("rst_beat_ignored");
        quiet_responder();
        do_read(32'h4000_0004, 1'b0, 32'h8888_9999, 0, 2);

        // Randomized mix
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 0)
                do_read($urandom, 1'($urandom_range(0, 1)), $urandom,
                        int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
            else
                do_write($urandom, $urandom, 4'($urandom_range(1, 15)),
                         int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                         int'($urandom_range(0, 6)));
        end

`ifdef AXI_INIT_TIMEOUT_EN
        // Responder never accepts the read address
        @(negedge clk);
        mem_valid = 1'b1;
        mem_instr = 1'b0;
        mem_addr  = 32'h0000_0ABC;
        mem_wstrb = 4'h0;
        for (int c = 1; c <= int'(TO) + 1; c++) begin
            @(negedge clk);
            chk1("to_arvalid", bus.arvalid, c <= int'(TO));
            chk1("to_ready",   mem_ready,   c == int'(TO) + 1);
            if (c == int'(TO) + 1) begin
                exp_rdata = 32'hDEAD_BEEF;
                exp_err   = 1'b1;
                chk("to_rdata", mem_rdata, exp_rdata);
                mem_valid = 1'b0;
            end
            chk1("to_err", mem_err, exp_err);
        end
        @(negedge clk);
        check_idle("to_after");
        do_read(32'h0000_0200, 1'b0, 32'h1357_9BDF, 1, 1);
        do_reset();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
